// File: rtl/tdm_pkg.sv
// ---------------------------------------------------------------------------
// tdm_pkg : shared TDM slot geometry and FSM encoding.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package tdm_pkg;

  localparam int N_SLOTS = 16;
  localparam int SEL_W   = $clog2(N_SLOTS);

  localparam logic [SEL_W-1:0] SLOT_LAST = SEL_W'(N_SLOTS - 1);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] COLLECT = 1'b1;

endpackage

`default_nettype wire

// File: rtl/tdm_slot_counter.sv
// ---------------------------------------------------------------------------
// tdm_slot_counter : wrapping slot index with load-to-1 and one-hot decode.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tdm_slot_counter
  import tdm_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load1_i,
  input  logic               inc_i,
  output logic [SEL_W-1:0]   slot_o,
  output logic [N_SLOTS-1:0] onehot_o
);

  logic [SEL_W-1:0]   slot_q;
  logic [SEL_W-1:0]   slot_d;
  logic [N_SLOTS-1:0] onehot_q;
  logic [N_SLOTS-1:0] onehot_d;

  // load1 wins over inc: a realigned or fresh frame always resumes at slot 1
  always_comb begin
    slot_d = slot_q;
    if (load1_i) begin
      slot_d = SEL_W'(1);
    end else if (inc_i) begin
      slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + SEL_W'(1);
    end
    onehot_d = N_SLOTS'(1) << slot_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_q   <= '0;
      onehot_q <= N_SLOTS'(1);
    end else begin
      slot_q   <= slot_d;
      onehot_q <= onehot_d;
    end
  end

  assign slot_o   = slot_q;
  assign onehot_o = onehot_q;

endmodule

`default_nettype wire

// File: rtl/tdm_demux1x16.sv
// ---------------------------------------------------------------------------
// tdm_demux1x16 : TDM receive demux, routes serial slots into a 16-bit word.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tdm_demux1x16
  import tdm_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               din_i,
  input  logic               din_valid_i,
  input  logic               frame_start_i,
  output logic [SEL_W-1:0]   slot_o,
  output logic [N_SLOTS-1:0] slot_onehot_o,
  output logic [N_SLOTS-1:0] word_out_o,
  output logic               word_valid_o,
  output logic               frame_err_o,
  output logic               busy_o
);

  logic [0:0]         state_q;
  logic [0:0]         state_d;
  logic [N_SLOTS-1:0] asm_q;
  logic [N_SLOTS-1:0] asm_d;
  logic [N_SLOTS-1:0] word_q;
  logic [N_SLOTS-1:0] word_d;
  logic               word_valid_q;
  logic               word_valid_d;
  logic               frame_err_q;
  logic               frame_err_d;
  logic               w_load1;
  logic               w_inc;
  logic [SEL_W-1:0]   w_slot;

  tdm_slot_counter u_slot_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load1_i  (w_load1),
    .inc_i    (w_inc),
    .slot_o   (w_slot),
    .onehot_o (slot_onehot_o)
  );

  always_comb begin
    state_d      = state_q;
    asm_d        = asm_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    w_load1      = 1'b0;
    w_inc        = 1'b0;

    case (state_q)
      IDLE: begin
        if (din_valid_i && frame_start_i) begin
          asm_d   = {{(N_SLOTS-1){1'b0}}, din_i};
          w_load1 = 1'b1;
          state_d = COLLECT;
        end
      end
      default: begin
        if (din_valid_i) begin
          if (frame_start_i && (w_slot != '0)) begin
            // Realign: the partial word is dropped and this bit becomes slot 0
            frame_err_d = 1'b1;
            asm_d       = {{(N_SLOTS-1){1'b0}}, din_i};
            w_load1     = 1'b1;
          end else begin
            asm_d[w_slot] = din_i;
            w_inc         = 1'b1;
            if (w_slot == SLOT_LAST) begin
              word_d       = {din_i, asm_q[N_SLOTS-2:0]};
              word_valid_d = 1'b1;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      asm_q        <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      asm_q        <= asm_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign slot_o       = w_slot;
  assign word_out_o   = word_q;
  assign word_valid_o = word_valid_q;
  assign frame_err_o  = frame_err_q;
  assign busy_o       = (state_q == COLLECT);

endmodule

`default_nettype wire

// File: tb/tb_tdm_demux1x16.sv
// ---------------------------------------------------------------------------
// tb_tdm_demux1x16 : scoreboard bench for the TDM receive demux.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_tdm_demux1x16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        din = 1'b0;
  logic        din_valid = 1'b0;
  logic        frame_start = 1'b0;
  logic [3:0]  slot;
  logic [15:0] slot_onehot;
  logic [15:0] word_out;
  logic        word_valid;
  logic        frame_err;
  logic        busy;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];
  int          wv_cyc[$];
  int          wv_cnt, ferr_cnt, wv_at, ferr_at, slot_bad;

  tdm_demux1x16 dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .din_i         (din),
    .din_valid_i   (din_valid),
    .frame_start_i (frame_start),
    .slot_o        (slot),
    .slot_onehot_o (slot_onehot),
    .word_out_o    (word_out),
    .word_valid_o  (word_valid),
    .frame_err_o   (frame_err),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  task automatic step(input logic d, input logic v, input logic fs);
    din = d; din_valid = v; frame_start = fs;
    @(posedge clk);
    #1;
    cyc++;
    din_valid = 1'b0; frame_start = 1'b0;
  endtask

  task automatic observe(input int k, input int exp_slot, input bit track);
    if (word_valid) begin
      wv_cnt++; wv_at = k; obs_q.push_back(word_out); wv_cyc.push_back(cyc);
    end
    if (frame_err) begin
      ferr_cnt++; ferr_at = k;
    end
    if (track && (slot !== 4'(exp_slot) || slot_onehot !== (16'h0001 << exp_slot))) slot_bad++;
  endtask

  // Serialises nbits of w LSB-first; expected word enters the scoreboard with its slot-15 bit
  task automatic send_word(input logic [15:0] w, input bit fs, input int nbits,
                           input int gap_every, input int gap_len, input bit track);
    wv_cnt = 0; ferr_cnt = 0; wv_at = -1; ferr_at = -1; slot_bad = 0;
    for (int k = 0; k < nbits; k++) begin
      if (k == 15) exp_q.push_back(w);
      step(w[k], 1'b1, fs && (k == 0));
      observe(k, (k + 1) % 16, track);
      if (gap_every > 0 && (k % gap_every) == gap_every - 1 && k != nbits - 1) begin
        for (int g = 0; g < gap_len; g++) begin
          step(1'b0, 1'b0, 1'b0);
          observe(k, (k + 1) % 16, track);
        end
      end
    end
  endtask

  task automatic test_reset;
    logic [15:0] e, o;
    send_word(16'hAAAA, 1'b1, 16, 0, 0, 1'b0);
    e = exp_q.pop_front();
    o = (obs_q.size() > 0) ? obs_q.pop_front() : 16'hxxxx;
    tests++; if (o !== e) begin fails++; $display("FAIL reset_preframe_word: got %h expected %h", o, e); end
    send_word(16'h0F0F, 1'b1, 5, 0, 0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (word_out !== 16'h0000) begin fails++; $display("FAIL reset_word_out: got %h expected 0000", word_out); end
    tests++; if (word_valid !== 1'b0) begin fails++; $display("FAIL reset_word_valid: got %b expected 0", word_valid); end
    tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests++; if (slot !== 4'd0) begin fails++; $display("FAIL reset_slot: got %0d expected 0", slot); end
    tests++; if (slot_onehot !== 16'h0001) begin fails++; $display("FAIL reset_onehot: got %h expected 0001", slot_onehot); end
    rst_n = 1'b1;
    send_word(16'h5A5A, 1'b1, 16, 0, 0, 1'b1);
    e = exp_q.pop_front();
    o = (obs_q.size() > 0) ? obs_q.pop_front() : 16'hxxxx;
    tests++; if (o !== e) begin fails++; $display("FAIL reset_postframe_word: got %h expected %h", o, e); end
    tests++; if (wv_cnt != 1) begin fails++; $display("FAIL reset_postframe_wv_count: got %0d expected 1", wv_cnt); end
  endtask

  task automatic test_basic;
    logic [15:0] e, o;
    send_word(16'hAAAA, 1'b1, 16, 0, 0, 1'b1);
    e = exp_q.pop_front();
    o = (obs_q.size() > 0) ? obs_q.pop_front() : 16'hxxxx;
    tests++; if (o !== e) begin fails++; $display("FAIL basic_word: got %h expected %h", o, e); end
    tests++; if (wv_cnt != 1) begin fails++; $display("FAIL basic_wv_count: got %0d expected 1", wv_cnt); end
    tests++; if (wv_at != 15) begin fails++; $display("FAIL basic_wv_latency: pulse after bit %0d expected 15", wv_at); end
    tests++; if (slot_bad != 0) begin fails++; $display("FAIL basic_slot_trace: got %0d bad cycles expected 0", slot_bad); end
    tests++; if (ferr_cnt != 0) begin fails++; $display("FAIL basic_frame_err: got %0d expected 0", ferr_cnt); end
    step(1'b0, 1'b0, 1'b0);
    tests++; if (word_valid !== 1'b0) begin fails++; $display("FAIL basic_wv_one_cycle: got %b expected 0", word_valid); end
    tests++; if (word_out !== 16'hAAAA) begin fails++; $display("FAIL basic_word_hold: got %h expected aaaa", word_out); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy: got %b expected 1", busy); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] e, o;
    int ferr_total, c0, c1;
    wv_cyc.delete();
    send_word(16'hAAAA, 1'b1, 16, 0, 0, 1'b1);
    ferr_total = ferr_cnt;
    send_word(16'h1234, 1'b0, 16, 0, 0, 1'b1);
    ferr_total += ferr_cnt;
    for (int n = 0; n < 2; n++) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 16'hxxxx;
      tests++; if (o !== e) begin fails++; $display("FAIL b2b_word%0d: got %h expected %h", n, o, e); end
    end
    c0 = (wv_cyc.size() > 0) ? wv_cyc[0] : -100;
    c1 = (wv_cyc.size() > 1) ? wv_cyc[1] : -100;
    tests++; if (c1 - c0 != 16) begin fails++; $display("FAIL b2b_spacing: got %0d cycles expected 16", c1 - c0); end
    tests++; if (ferr_total != 0) begin fails++; $display("FAIL b2b_frame_err: got %0d expected 0", ferr_total); end
    tests++; if (slot_bad != 0) begin fails++; $display("FAIL b2b_slot_trace: got %0d bad cycles expected 0", slot_bad); end
  endtask

  task automatic test_gapped;
    logic [15:0] e, o;
    send_word(16'hAAAA, 1'b1, 16, 4, 3, 1'b1);
    e = exp_q.pop_front();
    o = (obs_q.size() > 0) ? obs_q.pop_front() : 16'hxxxx;
    tests++; if (o !== e) begin fails++; $display("FAIL gap_word: got %h expected %h", o, e); end
    tests++; if (wv_cnt != 1) begin fails++; $display("FAIL gap_wv_count: got %0d expected 1", wv_cnt); end
    tests++; if (slot_bad != 0) begin fails++; $display("FAIL gap_slot_hold: got %0d bad cycles expected 0", slot_bad); end
  endtask

  task automatic test_realign;
    logic [15:0] e, o;
    int wv_partial, ferr_partial;
    send_word(16'h0F0F, 1'b1, 5, 0, 0, 1'b1);
    wv_partial = wv_cnt; ferr_partial = ferr_cnt;
    tests++; if (ferr_partial != 0 || wv_partial != 0) begin fails++; $display("FAIL realign_partial: got ferr %0d wv %0d expected 0 0", ferr_partial, wv_partial); end
    send_word(16'h00FF, 1'b1, 16, 0, 0, 1'b1);
    tests++; if (ferr_cnt != 1 || ferr_at != 0) begin fails++; $display("FAIL realign_frame_err: got %0d pulses at bit %0d expected 1 at 0", ferr_cnt, ferr_at); end
    tests++; if (slot_bad != 0) begin fails++; $display("FAIL realign_slot: got %0d bad cycles expected 0", slot_bad); end
    tests++; if (wv_cnt != 1 || wv_at != 15) begin fails++; $display("FAIL realign_wv: got %0d pulses at bit %0d expected 1 at 15", wv_cnt, wv_at); end
    e = exp_q.pop_front();
    o = (obs_q.size() > 0) ? obs_q.pop_front() : 16'hxxxx;
    tests++; if (o !== e) begin fails++; $display("FAIL realign_word: got %h expected %h", o, e); end
  endtask

  task automatic test_idle_filter;
    rst_n = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    send_word(16'h007F, 1'b0, 7, 0, 0, 1'b0);
    tests++; if (slot !== 4'd0) begin fails++; $display("FAIL idle_slot: got %0d expected 0", slot); end
    tests++; if (slot_onehot !== 16'h0001) begin fails++; $display("FAIL idle_onehot: got %h expected 0001", slot_onehot); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL idle_busy: got %b expected 0", busy); end
    tests++; if (wv_cnt != 0 || ferr_cnt != 0) begin fails++; $display("FAIL idle_pulses: got wv %0d ferr %0d expected 0 0", wv_cnt, ferr_cnt); end
    tests++; if (word_out !== 16'h0000) begin fails++; $display("FAIL idle_word_out: got %h expected 0000", word_out); end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_gapped();
    test_realign();
    test_idle_filter();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
